// File: rtl/lfsr49_prbs_checker.sv
// ---------------------------------------------------------------------------
// lfsr49_prbs_checker
//
// Receive-side checker for the 49-bit PRBS word stream produced by the LFSR
// generator (next word = {prev[47:0], prev[48] XNOR prev[39]}). The checker
// seeds itself from an incoming word, confirms LOCK_CNT consecutive matches,
// and then flywheels its own expected sequence. Every word checked while
// locked is counted. Every errored word is flagged and counted.
//
// Ports:
//   CLK         sole clock, rising edge
//   RESET_N     asynchronous active-low reset
//   CLEAR       synchronous clear of ERR_COUNT / WORD_COUNT only
//   DATA_VALID  qualifies DATA_IN
//   DATA_IN     received 49-bit PRBS word
//   LOCKED      high while STATE = LOCK
//   ERR_FLAG    one-cycle pulse per errored word while locked
//   ERR_COUNT   saturating error count (words, or bits with the macro)
//   WORD_COUNT  saturating count of words checked while locked
//   STATE       0 = HUNT, 1 = SYNC, 2 = LOCK
//
// Build option:
//   LFSR49_CHK_BITERR_EN  when defined, ERR_COUNT accumulates the number of
//                         differing bits per errored word instead of 1.
// ---------------------------------------------------------------------------
module lfsr49_prbs_checker #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CLEAR,
  input  logic                 DATA_VALID,
  input  logic [48:0]          DATA_IN,
  output logic                 LOCKED,
  output logic                 ERR_FLAG,
  output logic [CNT_WIDTH-1:0] ERR_COUNT,
  output logic [CNT_WIDTH-1:0] WORD_COUNT,
  output logic [1:0]           STATE
);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // The error adder must be wide enough for a 49-bit popcount even when the
  // counter itself is narrow, so the carry-out test still catches overflow.
  localparam int          SUM_W    = ((CNT_WIDTH > 6) ? CNT_WIDTH : 6) + 1;
  localparam logic [48:0] ALL_ONES = '1;

  state_t                r_state;
  logic                  r_locked;
  logic                  r_err_flag;
  logic [48:0]           r_exp;
  logic [7:0]            r_match_cnt;
  logic [7:0]            r_miss_cnt;
  logic [CNT_WIDTH-1:0]  r_err_cnt;
  logic [CNT_WIDTH-1:0]  r_word_cnt;

  logic                  w_mismatch;
  logic                  w_seed_ok;
  logic [48:0]           w_next_in;
  logic [48:0]           w_next_exp;
  logic [7:0]            w_match_nxt;
  logic [7:0]            w_miss_nxt;
  logic [5:0]            w_err_inc;
  logic [SUM_W-1:0]      w_err_sum;
  logic [CNT_WIDTH:0]    w_word_sum;
  logic [CNT_WIDTH-1:0]  w_err_sat;
  logic [CNT_WIDTH-1:0]  w_word_sat;

  function automatic logic [48:0] prbsNext(input logic [48:0] w);
    return {w[47:0], w[48] ~^ w[39]};
  endfunction

  assign w_mismatch  = (DATA_IN != r_exp);
  assign w_seed_ok   = (DATA_IN != ALL_ONES);
  assign w_next_in   = prbsNext(DATA_IN);
  assign w_next_exp  = prbsNext(r_exp);
  assign w_match_nxt = r_match_cnt + 8'd1;
  assign w_miss_nxt  = r_miss_cnt + 8'd1;

`ifdef LFSR49_CHK_BITERR_EN
  // Count the differing bits of the received word against the expected one.
  logic [48:0] w_diff;
  always_comb begin
    w_diff    = DATA_IN ^ r_exp;
    w_err_inc = '0;
    for (int i = 0; i < 49; i++) begin
      w_err_inc = w_err_inc + 6'(w_diff[i]);
    end
  end
`else
  assign w_err_inc = 6'd1;
`endif

  // Saturating increments: any carry beyond the counter width pins it at all-ones.
  assign w_err_sum  = SUM_W'(r_err_cnt) + SUM_W'(w_err_inc);
  assign w_err_sat  = (|w_err_sum[SUM_W-1:CNT_WIDTH]) ? '1 : w_err_sum[CNT_WIDTH-1:0];
  assign w_word_sum = {1'b0, r_word_cnt} + (CNT_WIDTH+1)'(1);
  assign w_word_sat = w_word_sum[CNT_WIDTH] ? '1 : w_word_sum[CNT_WIDTH-1:0];

  // HUNT/SYNC/LOCK machine plus counters. In LOCK the expected word advances
  // from its own value (flywheel), so a corrupted word never reseeds and is
  // counted once. CLEAR overrides any counter increment in the same cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_HUNT;
      r_locked    <= 1'b0;
      r_err_flag  <= 1'b0;
      r_exp       <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_err_cnt   <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_err_flag <= 1'b0;
      if (DATA_VALID) begin
        case (r_state)
          ST_HUNT: begin
            if (w_seed_ok) begin
              r_exp       <= w_next_in;
              r_match_cnt <= '0;
              r_state     <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (!w_mismatch) begin
              r_exp       <= w_next_in;
              r_match_cnt <= w_match_nxt;
              if (w_match_nxt == 8'(LOCK_CNT)) begin
                r_state    <= ST_LOCK;
                r_locked   <= 1'b1;
                r_miss_cnt <= '0;
              end
            end else if (w_seed_ok) begin
              r_exp       <= w_next_in;
              r_match_cnt <= '0;
            end else begin
              r_state <= ST_HUNT;
            end
          end
          ST_LOCK: begin
            r_exp <= w_next_exp;
            if (w_mismatch) begin
              r_err_flag <= 1'b1;
              r_miss_cnt <= w_miss_nxt;
              if (w_miss_nxt == 8'(UNLOCK_CNT)) begin
                r_state  <= ST_HUNT;
                r_locked <= 1'b0;
              end
            end else begin
              r_miss_cnt <= '0;
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end

      if (CLEAR) begin
        r_err_cnt  <= '0;
        r_word_cnt <= '0;
      end else if (DATA_VALID && (r_state == ST_LOCK)) begin
        r_word_cnt <= w_word_sat;
        if (w_mismatch) begin
          r_err_cnt <= w_err_sat;
        end
      end
    end
  end

  assign LOCKED     = r_locked;
  assign ERR_FLAG   = r_err_flag;
  assign ERR_COUNT  = r_err_cnt;
  assign WORD_COUNT = r_word_cnt;
  assign STATE      = r_state;

endmodule

// File: tb/tb_lfsr49_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr49_prbs_checker
//
// Self-checking bench for lfsr49_prbs_checker. A directed vector table walks
// through lock, single/multi-bit errors, clear, loss and relock. Short
// hand-written sequences cover illegal seeds, gapped valids and asynchronous
// reset. A randomized run is compared against a behavioural model. A second
// instance with 4-bit counters exposes saturation.
// ---------------------------------------------------------------------------
module tb_lfsr49_prbs_checker;

  localparam int          LOCK_CNT   = 16;
  localparam int          UNLOCK_CNT = 4;
  localparam int          CNT_W      = 32;
  localparam int          SMALL_W    = 4;
  localparam logic [48:0] ALL_ONES   = '1;
  localparam logic [48:0] SEED       = 49'h1_55AA_AA55_55AA;
  localparam longint      CAP_BIG    = (64'sd1 << CNT_W) - 1;
  localparam longint      CAP_SMALL  = (64'sd1 << SMALL_W) - 1;
`ifdef LFSR49_CHK_BITERR_EN
  localparam int          TRIPLE_INC = 3;
`else
  localparam int          TRIPLE_INC = 1;
`endif

  logic                CLK = 1'b0;
  logic                RESET_N = 1'b0;
  logic                CLEAR = 1'b0;
  logic                DATA_VALID = 1'b0;
  logic [48:0]         DATA_IN = '0;
  logic                LOCKED, ERR_FLAG;
  logic [CNT_W-1:0]    ERR_COUNT, WORD_COUNT;
  logic [1:0]          STATE;
  logic                lockedSmall, errFlagSmall;
  logic [SMALL_W-1:0]  errCountSmall, wordCountSmall;
  logic [1:0]          stateSmall;

  lfsr49_prbs_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_WIDTH(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .DATA_VALID(DATA_VALID), .DATA_IN(DATA_IN),
    .LOCKED(LOCKED), .ERR_FLAG(ERR_FLAG), .ERR_COUNT(ERR_COUNT), .WORD_COUNT(WORD_COUNT),
    .STATE(STATE)
  );

  lfsr49_prbs_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_WIDTH(SMALL_W)) dutSmall (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .DATA_VALID(DATA_VALID), .DATA_IN(DATA_IN),
    .LOCKED(lockedSmall), .ERR_FLAG(errFlagSmall), .ERR_COUNT(errCountSmall),
    .WORD_COUNT(wordCountSmall), .STATE(stateSmall)
  );

  always #5 CLK = ~CLK;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    bit          valid;
    bit          clr;
    logic [48:0] flip;
    int          expState;
    bit          expLocked;
    bit          expFlag;
    longint      expErr;
    longint      expWords;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  int          mState;
  logic [48:0] mExp;
  int          mMatch, mMiss;
  bit          mFlag;
  longint      mErr, mWords, mErr4, mWords4;

  function automatic logic [48:0] prbsNext(input logic [48:0] w);
    return {w[47:0], ~(w[48] ^ w[39])};
  endfunction

  function automatic logic [48:0] rnd49();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[48:0];
  endfunction

  function automatic longint satAdd(input longint a, input longint b, input longint cap);
    return (a + b > cap) ? cap : a + b;
  endfunction

  function automatic void addVec(input bit valid, input bit clr, input logic [48:0] flip,
                                 input int st, input bit lk, input bit fl,
                                 input longint er, input longint wd);
    vec_t v;
    v.valid = valid; v.clr = clr; v.flip = flip; v.expState = st;
    v.expLocked = lk; v.expFlag = fl; v.expErr = er; v.expWords = wd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit valid, input logic [48:0] data, input bit clr);
    @(negedge CLK);
    DATA_VALID = valid;
    DATA_IN    = data;
    CLEAR      = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int st, input bit lk, input bit fl,
                             input longint er, input longint wd);
    check({tag, " state"},  64'(STATE),      64'(st));
    check({tag, " locked"}, 64'(LOCKED),     64'(lk));
    check({tag, " flag"},   64'(ERR_FLAG),   64'(fl));
    check({tag, " errs"},   64'(ERR_COUNT),  64'(er));
    check({tag, " words"},  64'(WORD_COUNT), 64'(wd));
  endtask

  task automatic doReset();
    RESET_N    = 1'b0;
    DATA_VALID = 1'b0;
    CLEAR      = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic modelReset();
    mState = 0; mExp = '0; mMatch = 0; mMiss = 0; mFlag = 0;
    mErr = 0; mWords = 0; mErr4 = 0; mWords4 = 0;
  endtask

  // One received-word step of the checker behaviour described for the link.
  task automatic modelStep(input bit valid, input logic [48:0] data, input bit clr);
    int inc;
    mFlag = 0;
    if (valid) begin
      if (mState == 0) begin
        if (data != ALL_ONES) begin
          mExp = prbsNext(data); mMatch = 0; mState = 1;
        end
      end else if (mState == 1) begin
        if (data == mExp) begin
          mExp = prbsNext(data);
          mMatch++;
          if (mMatch == LOCK_CNT) begin mState = 2; mMiss = 0; end
        end else if (data != ALL_ONES) begin
          mExp = prbsNext(data); mMatch = 0;
        end else begin
          mState = 0;
        end
      end else begin
`ifdef LFSR49_CHK_BITERR_EN
        inc = $countones(data ^ mExp);
`else
        inc = 1;
`endif
        mWords  = satAdd(mWords, 1, CAP_BIG);
        mWords4 = satAdd(mWords4, 1, CAP_SMALL);
        if (data != mExp) begin
          mFlag = 1;
          mErr  = satAdd(mErr, inc, CAP_BIG);
          mErr4 = satAdd(mErr4, inc, CAP_SMALL);
          mMiss++;
          if (mMiss == UNLOCK_CNT) mState = 0;
        end else begin
          mMiss = 0;
        end
        mExp = prbsNext(mExp);
      end
    end
    if (clr) begin
      mErr = 0; mWords = 0; mErr4 = 0; mWords4 = 0;
    end
  endtask

  initial begin
    logic [48:0] gen;
    logic [48:0] data;
    logic [48:0] tripleMask;
    int          burstLeft;

    // ---------------- reset state ----------------
    doReset();
    checkOutput("reset", 0, 0, 0, 0, 0);

    // ---------------- directed vector table ----------------
    tripleMask = (49'd1 << 48) | (49'd1 << 20) | 49'd1;
    for (int k = 1; k <= 16; k++) addVec(1, 0, '0, 1, 0, 0, 0, 0);
    addVec(1, 0, '0, 2, 1, 0, 0, 0);
    for (int k = 1; k <= 3; k++) addVec(1, 0, '0, 2, 1, 0, 0, k);
    addVec(0, 0, '0, 2, 1, 0, 0, 3);
    addVec(1, 0, 49'd1, 2, 1, 1, 1, 4);
    addVec(1, 0, '0, 2, 1, 0, 1, 5);
    addVec(1, 0, '0, 2, 1, 0, 1, 6);
    addVec(1, 0, tripleMask, 2, 1, 1, 1 + TRIPLE_INC, 7);
    addVec(1, 0, '0, 2, 1, 0, 1 + TRIPLE_INC, 8);
    addVec(1, 1, 49'd1 << 5, 2, 1, 1, 0, 0);
    addVec(1, 0, '0, 2, 1, 0, 0, 1);
    for (int k = 1; k <= 4; k++)
      addVec(1, 0, 49'd1 << k, (k == 4) ? 0 : 2, (k != 4), 1, k, 1 + k);
    for (int k = 1; k <= 16; k++) addVec(1, 0, '0, 1, 0, 0, 4, 5);
    addVec(1, 0, '0, 2, 1, 0, 4, 5);
    addVec(1, 0, '0, 2, 1, 0, 4, 6);

    gen = SEED;
    for (int i = 0; i < vecs.size(); i++) begin
      data = vecs[i].valid ? (gen ^ vecs[i].flip) : rnd49();
      applyStimulus(vecs[i].valid, data, vecs[i].clr);
      if (vecs[i].valid) gen = prbsNext(gen);
      checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expLocked,
                  vecs[i].expFlag, vecs[i].expErr, vecs[i].expWords);
    end

    // ---------------- illegal all-ones seed ----------------
    doReset();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, ALL_ONES, 0);
      check($sformatf("allones%0d state", k), 64'(STATE), 64'd0);
    end

    // ---------------- lock with gaps between valid words ----------------
    doReset();
    gen = rnd49();
    if (gen == ALL_ONES) gen = SEED;
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(1, gen, 0);
      gen = prbsNext(gen);
      check($sformatf("gap word%0d state", k), 64'(STATE), (k == 17) ? 64'd2 : 64'd1);
      check($sformatf("gap word%0d locked", k), 64'(LOCKED), (k == 17) ? 64'd1 : 64'd0);
      applyStimulus(0, rnd49(), 0);
      check($sformatf("gap idle%0d state", k), 64'(STATE), (k == 17) ? 64'd2 : 64'd1);
      check($sformatf("gap idle%0d flag", k), 64'(ERR_FLAG), 64'd0);
    end
    applyStimulus(1, gen ^ 49'd8, 0);
    gen = prbsNext(gen);
    checkOutput("gap err", 2, 1, 1, 1, 1);

    // ---------------- asynchronous reset between edges ----------------
    @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("async reset", 0, 0, 0, 0, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // ---------------- randomized run against the model ----------------
    doReset();
    modelReset();
    gen = SEED;
    burstLeft = 0;
    for (int c = 0; c < 3000; c++) begin
      int  r;
      bit  valid, clr;
      logic [48:0] mask;
      r     = $urandom_range(0, 999);
      valid = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 59) == 0);
      if (r < 5) begin
        gen = rnd49();
        if (gen == ALL_ONES) gen = SEED;
      end
      if (r >= 60 && r < 68) burstLeft = 5;
      data = gen;
      if ((r >= 5 && r < 60) || (valid && burstLeft > 0)) begin
        mask = 49'd1 << $urandom_range(0, 48);
        if ($urandom_range(0, 1) == 1) mask = mask | (rnd49() & rnd49() & rnd49());
        data = data ^ mask;
      end
      if (r >= 995) data = ALL_ONES;
      if (!valid) data = rnd49();
      applyStimulus(valid, data, clr);
      if (valid) begin
        gen = prbsNext(gen);
        if (burstLeft > 0) burstLeft--;
      end
      modelStep(valid, data, clr);
      checkOutput($sformatf("rnd%0d", c), mState, (mState == 2), mFlag, mErr, mWords);
      check($sformatf("rnd%0d errs4", c), 64'(errCountSmall), 64'(mErr4));
      check($sformatf("rnd%0d words4", c), 64'(wordCountSmall), 64'(mWords4));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
